// File: rtl/apu_issue_queue.sv
// In-order issue queue between the core APU port and vector_decoder.
// Buffers up to DEPTH instructions, issues one at a time and returns each result registered.
module apu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             core_apu_req,
  output logic             core_apu_gnt,
  input  logic [2:0][31:0] core_apu_operands,
  input  logic [5:0]       core_apu_op,
  input  logic [14:0]      core_apu_flags_i,
  output logic             core_apu_rvalid,
  output logic [31:0]      core_apu_result,
  output logic             dec_apu_req,
  input  logic             dec_apu_gnt,
  output logic [2:0][31:0] dec_apu_operands,
  output logic [5:0]       dec_apu_op,
  output logic [14:0]      dec_apu_flags_i,
  input  logic             dec_apu_rvalid,
  input  logic [31:0]      dec_result,
  input  logic             flush,
  output logic [CW-1:0]    queue_count,
  output logic             busy
);
  // state    | meaning
  // IDLE     | decoder free; head entry is offered whenever the queue is non-empty
  // INFLIGHT | one instruction executing in the decoder, waiting for dec_apu_rvalid
  typedef enum logic {IDLE, INFLIGHT} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 3 * 32 + 6 + 15;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state, state_nxt;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Grant looks only at registered occupancy, so a same-cycle pop never opens a slot.
  assign core_apu_gnt = (count != FULL) & ~flush;
  assign push         = core_apu_req & core_apu_gnt;

  assign {dec_apu_operands, dec_apu_op, dec_apu_flags_i} = mem[rd_ptr];

  always_comb begin
    state_nxt   = state;
    dec_apu_req = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        dec_apu_req = (count != '0);
        pop         = dec_apu_req & dec_apu_gnt;
        if (pop) state_nxt = INFLIGHT;
      end
      INFLIGHT: begin
        if (dec_apu_rvalid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {core_apu_operands, core_apu_op, core_apu_flags_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      // A pop coinciding with flush still issues; flush only drops what remains.
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      core_apu_rvalid <= 1'b0;
      core_apu_result <= '0;
    end else begin
      core_apu_rvalid <= (state == INFLIGHT) & dec_apu_rvalid;
      if ((state == INFLIGHT) & dec_apu_rvalid) core_apu_result <= dec_result;
    end
  end

  assign queue_count = count;
  assign busy        = (count != '0) | (state == INFLIGHT) | core_apu_rvalid;

endmodule
